// File: rtl/bg_scene_sequencer.sv
// Background scene controller: picks one of four VGA background sources and
// animates scene changes as a left-to-right wipe, updating state only at frame start.
module bg_scene_sequencer #(
    parameter int DWELL_FRAMES = 300,
    parameter int WIPE_STEP    = 32,
    parameter int H_ACTIVE     = 640
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       mode_auto,
    input  logic [1:0] sel_in,
    input  logic       btn_next,
    output logic [1:0] bg_sel,
    output logic [1:0] cur_scene,
    output logic       busy,
    output logic       scene_done
);

    localparam int              DW_W       = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_FRAMES - 1);
    localparam logic [10:0]     STEP       = 11'(WIPE_STEP);
    localparam logic [10:0]     H_END      = 11'(H_ACTIVE);

    typedef enum logic {SHOW = 1'b0, WIPE = 1'b1} state_t;

    state_t          state_q, state_d;
    logic            frame_tick_q, frame_tick_d;
    logic [1:0]      cur_q, cur_d;
    logic [1:0]      nxt_q, nxt_d;
    logic [1:0]      bg_sel_q, bg_sel_d;
    logic [10:0]     wipe_x_q, wipe_x_d;
    logic [DW_W-1:0] dwell_q, dwell_d;
    logic [1:0]      btn_hist_q, btn_hist_d;
    logic            done_q, done_d;
    logic [10:0]     wipe_sum;
    logic            press;
    logic            wipe_end;

    // Press = high on two consecutive frame samples after a low one.
    assign press    = btn_next & btn_hist_q[0] & ~btn_hist_q[1];
    assign wipe_sum = wipe_x_q + STEP;
    assign wipe_end = (wipe_sum >= H_END);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= SHOW;
            frame_tick_q <= 1'b0;
            cur_q        <= 2'd0;
            nxt_q        <= 2'd0;
            bg_sel_q     <= 2'd0;
            wipe_x_q     <= 11'd0;
            dwell_q      <= '0;
            btn_hist_q   <= 2'b00;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_tick_q <= frame_tick_d;
            cur_q        <= cur_d;
            nxt_q        <= nxt_d;
            bg_sel_q     <= bg_sel_d;
            wipe_x_q     <= wipe_x_d;
            dwell_q      <= dwell_d;
            btn_hist_q   <= btn_hist_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        nxt_d        = nxt_q;
        wipe_x_d     = wipe_x_q;
        dwell_d      = dwell_q;
        btn_hist_d   = btn_hist_q;
        done_d       = 1'b0;
        frame_tick_d = (pix_x == 10'd0) && (pix_y == 10'd0);

        if (frame_tick_q) begin
            btn_hist_d = {btn_hist_q[0], btn_next};
            if (state_q == WIPE) begin
                // Inputs are ignored mid-wipe; a pending sel_in is picked up in SHOW.
                dwell_d = '0;
                if (wipe_end) begin
                    cur_d    = nxt_q;
                    state_d  = SHOW;
                    wipe_x_d = 11'd0;
                    done_d   = 1'b1;
                end else begin
                    wipe_x_d = wipe_sum;
                end
            end else if (!mode_auto) begin
                dwell_d = '0;
                if (sel_in != cur_q) begin
                    state_d  = WIPE;
                    nxt_d    = sel_in;
                    wipe_x_d = 11'd0;
                end
            end else if (press || (dwell_q == DWELL_LAST)) begin
                state_d  = WIPE;
                nxt_d    = cur_q + 2'd1;
                wipe_x_d = 11'd0;
                dwell_d  = '0;
            end else begin
                dwell_d = dwell_q + DW_W'(1);
            end
        end
    end

    always_comb begin
        bg_sel_d = cur_q;
        if ((state_q == WIPE) && ({1'b0, pix_x} < wipe_x_q)) begin
            bg_sel_d = nxt_q;
        end
    end

    assign bg_sel     = bg_sel_q;
    assign cur_scene  = cur_q;
    assign busy       = (state_q == WIPE);
    assign scene_done = done_q;

endmodule
